// File: rtl/weight_init_sequencer.sv
// Writes NUM_WEIGHTS LFSR-derived signed weights into the weight RAM, then reads
// every word back against the regenerated sequence and reports Done/Error.
module weight_init_sequencer #(
  parameter int                NUM_WEIGHTS = 100,
  parameter int                ADDR_W      = 7,
  parameter int                DATA_W      = 10,
  parameter logic [DATA_W-1:0] SEED        = 10'h2A5,
  parameter int                SHIFT       = 2
) (
  input  logic                     Clock,
  input  logic                     Rst,
  input  logic                     Start,
  input  logic                     wr_ready,
  output logic                     wr_en,
  output logic        [ADDR_W-1:0] wr_addr,
  output logic signed [DATA_W-1:0] wr_data,
  output logic                     rd_en,
  output logic        [ADDR_W-1:0] rd_addr,
  input  logic signed [DATA_W-1:0] rd_data,
  output logic                     Busy,
  output logic                     Done,
  output logic                     Error,
  output logic        [ADDR_W-1:0] err_addr
);

  typedef enum logic [2:0] {IDLE, WRITE, VREQ, VCHK, DONE} state_t;

  localparam logic [DATA_W-1:0] SEED_EFF = (SEED == '0) ? DATA_W'(1) : SEED;
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(NUM_WEIGHTS - 1);

  state_t             state_reg;
  logic [DATA_W-1:0]  lfsr_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic               fin_reg;
  logic               mismatch_reg;

  logic [DATA_W-1:0]  lfsr_next;
  logic [ADDR_W-1:0]  addr_next;

  // x^10 + x^7 + 1, maximal length
  assign lfsr_next = {lfsr_reg[8:0], lfsr_reg[9] ^ lfsr_reg[6]};
  assign addr_next = addr_reg + ADDR_W'(1);

  function automatic logic signed [DATA_W-1:0] weight_of(input logic [DATA_W-1:0] v);
    return $signed(v) >>> SHIFT;
  endfunction

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      state_reg    <= IDLE;
      lfsr_reg     <= SEED_EFF;
      addr_reg     <= '0;
      fin_reg      <= 1'b0;
      mismatch_reg <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Error        <= 1'b0;
      err_addr     <= '0;
    end else begin
      unique case (state_reg)
        IDLE, DONE: begin
          if (Start) begin
            state_reg    <= WRITE;
            lfsr_reg     <= SEED_EFF;
            addr_reg     <= '0;
            fin_reg      <= 1'b0;
            mismatch_reg <= 1'b0;
            wr_en        <= 1'b1;
            wr_addr      <= '0;
            wr_data      <= weight_of(SEED_EFF);
            Busy         <= 1'b1;
            Done         <= 1'b0;
            Error        <= 1'b0;
            err_addr     <= '0;
          end
        end
        WRITE: begin
          // wr_en is always high here, so wr_ready alone marks a transfer
          if (wr_ready) begin
            if (addr_reg == LAST) begin
              state_reg <= VREQ;
              lfsr_reg  <= SEED_EFF;
              addr_reg  <= '0;
              wr_en     <= 1'b0;
              rd_en     <= 1'b1;
              rd_addr   <= '0;
            end else begin
              lfsr_reg  <= lfsr_next;
              addr_reg  <= addr_next;
              wr_addr   <= addr_next;
              wr_data   <= weight_of(lfsr_next);
            end
          end
        end
        VREQ: begin
          rd_en     <= 1'b0;
          state_reg <= VCHK;
        end
        VCHK: begin
          // The verdict is latched for one cycle before Done/Error are published.
          if (fin_reg) begin
            state_reg <= DONE;
            Busy      <= 1'b0;
            Done      <= 1'b1;
            Error     <= mismatch_reg;
            if (mismatch_reg) err_addr <= addr_reg;
          end else if (rd_data != weight_of(lfsr_reg)) begin
            mismatch_reg <= 1'b1;
            fin_reg      <= 1'b1;
          end else if (addr_reg == LAST) begin
            fin_reg <= 1'b1;
          end else begin
            lfsr_reg  <= lfsr_next;
            addr_reg  <= addr_next;
            rd_en     <= 1'b1;
            rd_addr   <= addr_next;
            state_reg <= VREQ;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_init_sequencer.sv
// Directed bench for weight_init_sequencer with NUM_WEIGHTS=4 and a behavioural RAM.
module tb_weight_init_sequencer;
  localparam int N  = 4;
  localparam int AW = 7;
  localparam int DW = 10;

  logic                 Clock = 1'b0;
  logic                 Rst = 1'b0;
  logic                 Start = 1'b0;
  logic                 wr_ready = 1'b0;
  logic                 wr_en, rd_en, Busy, Done, Error;
  logic        [AW-1:0] wr_addr, rd_addr, err_addr;
  logic signed [DW-1:0] wr_data, rd_data;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int viol = 0;
  logic corrupt = 1'b0;
  logic rd_en_q = 1'b0;

  logic signed [DW-1:0] mem [0:(1<<AW)-1];
  logic signed [DW-1:0] wlog[$];
  int                   rdlog[$];
  // hand-computed: 0x2A5>>>2, 0x14B>>>2, 0x297>>>2, 0x12F>>>2
  logic signed [DW-1:0] exp_w [0:3] = '{-10'sd87, 10'sd82, -10'sd91, 10'sd75};

  weight_init_sequencer #(.NUM_WEIGHTS(N), .ADDR_W(AW), .DATA_W(DW),
                          .SEED(10'h2A5), .SHIFT(2)) dut (
    .Clock(Clock), .Rst(Rst), .Start(Start), .wr_ready(wr_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .Busy(Busy), .Done(Done), .Error(Error), .err_addr(err_addr)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  // RAM model plus protocol monitor
  always @(posedge Clock) begin
    if (wr_en && wr_ready) begin
      mem[wr_addr] <= wr_data;
      wlog.push_back(wr_data);
      $display("[TB] t=%0t write addr=%0d data=%0d", $time, wr_addr, wr_data);
    end
    if (rd_en) begin
      if (corrupt && rd_addr == 2) rd_data <= {mem[rd_addr][DW-1:1], ~mem[rd_addr][0]};
      else                          rd_data <= mem[rd_addr];
      rdlog.push_back(int'(rd_addr));
      $display("[TB] t=%0t read  addr=%0d", $time, rd_addr);
    end
    if ((rd_en && rd_en_q) || (rd_en && wr_en)) viol <= viol + 1;
    rd_en_q <= rd_en;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_start(output int e0);
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_done(input int e0, output int lat);
    int k = 0;
    while (!Done && k < 200) begin
      @(posedge Clock); #1;
      k++;
    end
    lat = cyc - e0;
  endtask

  task automatic test_reset;
    #12;
    tests++;
    if ({wr_en, rd_en, Busy, Done, Error, wr_addr, rd_addr, err_addr, wr_data} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %b want all 0",
               {wr_en, rd_en, Busy, Done, Error, wr_addr, rd_addr, err_addr, wr_data});
    end
    @(posedge Clock); #1;
    Rst = 1'b1;
    wr_ready = 1'b1;
    repeat (5) begin @(posedge Clock); #1; end
    tests++;
    if ({Busy, Done, wr_en, rd_en} !== 4'b0000) begin
      fails++; $display("FAIL reset_idle: got busy/done/wr/rd=%b want 0000", {Busy, Done, wr_en, rd_en});
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_nominal;
    int e0, lat;
    wlog.delete(); rdlog.delete();
    do_start(e0);
    tests++;
    if ({Busy, wr_en, Done} !== 3'b110 || wr_addr !== 0 || wr_data !== -10'sd87) begin
      fails++;
      $display("FAIL nominal_first: busy/wr/done=%b addr=%0d data=%0d want 110 0 -87",
               {Busy, wr_en, Done}, wr_addr, wr_data);
    end
    @(posedge Clock); #1;
    tests++;
    if (wr_addr !== 1 || wr_data !== 10'sd82) begin
      fails++; $display("FAIL nominal_second: addr=%0d data=%0d want 1 82", wr_addr, wr_data);
    end
    wait_done(e0, lat);
    tests++;
    if (lat !== 13) begin fails++; $display("FAIL nominal_latency: got %0d want 13", lat); end
    tests++;
    if (Error !== 1'b0 || Busy !== 1'b0) begin
      fails++; $display("FAIL nominal_flags: error=%b busy=%b want 0 0", Error, Busy);
    end
    tests++;
    if (wlog.size() != N) begin
      fails++; $display("FAIL nominal_wcount: got %0d want %0d", wlog.size(), N);
    end else begin
      for (int i = 0; i < N; i++) begin
        tests++;
        if (wlog[i] !== exp_w[i]) begin
          fails++; $display("FAIL nominal_wdata[%0d]: got %0d want %0d", i, wlog[i], exp_w[i]);
        end
      end
    end
    tests++;
    if (rdlog.size() != N || rdlog[0] != 0 || rdlog[N-1] != N-1) begin
      fails++; $display("FAIL nominal_reads: got %0d reads want %0d in order", rdlog.size(), N);
    end
    $display("[TB] test_nominal done");
  endtask

  task automatic test_backpressure;
    int e0, lat;
    wlog.delete();
    do_start(e0);
    @(posedge Clock); #1;
    wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock); #1;
      tests++;
      if (wr_en !== 1'b1 || wr_addr !== 1 || wr_data !== 10'sd82) begin
        fails++;
        $display("FAIL bp_hold[%0d]: en=%b addr=%0d data=%0d want 1 1 82", i, wr_en, wr_addr, wr_data);
      end
    end
    wr_ready = 1'b1;
    wait_done(e0, lat);
    tests++;
    if (lat !== 16) begin fails++; $display("FAIL bp_latency: got %0d want 16", lat); end
    tests++;
    if (wlog.size() != N || wlog[1] !== exp_w[1] || wlog[2] !== exp_w[2] || Error !== 1'b0) begin
      fails++; $display("FAIL bp_data: writes=%0d error=%b want %0d 0", wlog.size(), Error, N);
    end
    $display("[TB] test_backpressure done");
  endtask

  task automatic test_verify_fail;
    int e0, lat;
    rdlog.delete();
    corrupt = 1'b1;
    do_start(e0);
    wait_done(e0, lat);
    tests++;
    if (lat !== 11) begin fails++; $display("FAIL vf_latency: got %0d want 11", lat); end
    tests++;
    if (Error !== 1'b1 || Done !== 1'b1 || err_addr !== 2) begin
      fails++; $display("FAIL vf_flags: error=%b done=%b err_addr=%0d want 1 1 2", Error, Done, err_addr);
    end
    repeat (3) begin @(posedge Clock); #1; end
    tests++;
    if (rdlog.size() != 3 || rdlog[2] != 2) begin
      fails++; $display("FAIL vf_reads: got %0d reads want 3 (no read of addr 3)", rdlog.size());
    end
    tests++;
    if (Done !== 1'b1 || Error !== 1'b1) begin
      fails++; $display("FAIL vf_hold: done=%b error=%b want 1 1", Done, Error);
    end
    corrupt = 1'b0;
    $display("[TB] test_verify_fail done");
  endtask

  task automatic test_start_handling;
    int e0, lat;
    wlog.delete();
    do_start(e0);
    tests++;
    if (Done !== 1'b0 || Error !== 1'b0 || Busy !== 1'b1 || err_addr !== 0) begin
      fails++;
      $display("FAIL sh_clear: done=%b error=%b busy=%b err_addr=%0d want 0 0 1 0", Done, Error, Busy, err_addr);
    end
    @(posedge Clock); #1;
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    tests++;
    if (wr_addr !== 2) begin fails++; $display("FAIL sh_no_restart: wr_addr=%0d want 2", wr_addr); end
    wait_done(e0, lat);
    tests++;
    if (lat !== 13 || Error !== 1'b0) begin
      fails++; $display("FAIL sh_rerun: latency=%0d error=%b want 13 0", lat, Error);
    end
    tests++;
    if (wlog.size() != N || wlog[0] !== exp_w[0] || wlog[3] !== exp_w[3]) begin
      fails++; $display("FAIL sh_data: writes=%0d want %0d identical", wlog.size(), N);
    end
    $display("[TB] test_start_handling done");
  endtask

  task automatic test_back_to_back;
    int e0, e1, lat;
    Start = 1'b1;
    @(posedge Clock); #1;
    e0 = cyc;
    wait_done(e0, lat);
    tests++;
    if (lat !== 13) begin fails++; $display("FAIL b2b_first: latency=%0d want 13", lat); end
    @(posedge Clock); #1;
    e1 = cyc;
    Start = 1'b0;
    tests++;
    if (Done !== 1'b0 || Busy !== 1'b1 || wr_addr !== 0 || wr_data !== -10'sd87) begin
      fails++;
      $display("FAIL b2b_restart: done=%b busy=%b addr=%0d data=%0d want 0 1 0 -87", Done, Busy, wr_addr, wr_data);
    end
    wait_done(e1, lat);
    tests++;
    if (lat !== 13) begin fails++; $display("FAIL b2b_second: latency=%0d want 13", lat); end
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_reset_mid_verify;
    int e0, lat, k;
    do_start(e0);
    k = 0;
    while (!rd_en && k < 50) begin @(posedge Clock); #1; k++; end
    tests++;
    if (rd_en !== 1'b1) begin fails++; $display("FAIL rmv_rd_en: got %b want 1", rd_en); end
    @(posedge Clock); #3;
    Rst = 1'b0;
    #1;
    tests++;
    if ({wr_en, rd_en, Busy, Done, Error, wr_addr, rd_addr, err_addr, wr_data} !== '0) begin
      fails++;
      $display("FAIL rmv_async: got %b want all 0",
               {wr_en, rd_en, Busy, Done, Error, wr_addr, rd_addr, err_addr, wr_data});
    end
    @(posedge Clock); #1;
    Rst = 1'b1;
    @(posedge Clock); #1;
    wlog.delete();
    do_start(e0);
    tests++;
    if (wr_addr !== 0 || wr_data !== -10'sd87 || Busy !== 1'b1) begin
      fails++; $display("FAIL rmv_restart: addr=%0d data=%0d busy=%b want 0 -87 1", wr_addr, wr_data, Busy);
    end
    wait_done(e0, lat);
    tests++;
    if (lat !== 13 || Error !== 1'b0 || wlog.size() != N) begin
      fails++; $display("FAIL rmv_run: latency=%0d error=%b writes=%0d want 13 0 %0d", lat, Error, wlog.size(), N);
    end
    $display("[TB] test_reset_mid_verify done");
  endtask

  task automatic test_protocol;
    tests++;
    if (viol != 0) begin
      fails++; $display("FAIL protocol: got %0d rd_en/wr_en overlap or back-to-back rd_en events want 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_verify_fail();
    test_start_handling();
    test_back_to_back();
    test_reset_mid_verify();
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
